// File: rtl/b2a_pkg.sv
// Shared defaults, result tag and scheduler state for the B2A conversion scheduler.
package b2a_pkg;
  localparam int B2A_K_WIDTH  = 32;
  localparam int B2A_N_SHARES = 3;
  localparam int B2A_ID_W     = 4;
  localparam int B2A_DEPTH    = 32;

  // Travels alongside each in-flight conversion so the result can be routed back
  typedef struct packed {
    logic                src;
    logic [B2A_ID_W-1:0] id;
  } tag_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/b2a_tag_fifo.sv
// Register FIFO holding tags of conversions in flight; pops on an empty FIFO
// and pushes on a full one (without a same-cycle pop) are dropped.
module b2a_tag_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_din,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_dout,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push, w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  // A same-cycle pop frees the slot, so a full FIFO can still accept
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_dout    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Tag storage written at the write pointer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointers wrap naturally mod DEPTH; count tracks occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/b2a_sched.sv
// Shares one fixed-latency masked B2A datapath between two requesters:
// round-robin issue, randomness/backpressure-gated enable, tag return path.
module b2a_sched
  import b2a_pkg::*;
#(
  parameter int K_WIDTH   = B2A_K_WIDTH,
  parameter int N_SHARES  = B2A_N_SHARES,
  parameter int MASKWIDTH = K_WIDTH * N_SHARES,
  parameter int ID_W      = B2A_ID_W,
  parameter int DEPTH     = B2A_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [1:0]             i_req_vld,
  output logic [1:0]             o_req_rdy,
  input  logic [2*MASKWIDTH-1:0] i_req_b,
  input  logic [2*ID_W-1:0]      i_req_id,
  input  logic                   i_rnd_vld,
  output logic                   o_rnd_en,
  output logic                   o_dp_dvld,
  output logic [MASKWIDTH-1:0]   o_dp_b,
  input  logic                   i_dp_dvld,
  input  logic [MASKWIDTH-1:0]   i_dp_a,
  input  logic                   i_flush,
  output logic                   o_vld,
  input  logic                   i_rdy,
  output logic [MASKWIDTH-1:0]   o_a,
  output logic                   o_src,
  output logic [ID_W-1:0]        o_id,
  output logic                   o_busy,
  output logic                   o_err
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_t        r_state, w_state_nxt;
  logic          r_rr_pri;   // requester currently holding priority
  logic          r_err;
  logic          w_pop, w_pop_eff, w_push, w_any_req, w_win;
  logic          w_full, w_empty;
  logic [CW-1:0] w_count, w_count_nxt;
  tag_t          w_push_tag, w_head;

  // The whole datapath stalls when randomness is missing or a result is blocked
  assign o_rnd_en  = i_rnd_vld & ~(i_dp_dvld & ~i_rdy);
  assign o_vld     = i_dp_dvld & i_rnd_vld;
  assign o_a       = i_dp_a;
  assign w_pop     = o_vld & i_rdy;
  assign w_pop_eff = w_pop & ~w_empty;
  assign o_src     = w_head.src;
  assign o_id      = w_head.id;
  assign o_busy    = (r_state != IDLE);
  assign o_err     = r_err;

  // Round-robin pick: priority holder wins if valid, otherwise the other one
  assign w_any_req  = |i_req_vld;
  assign w_win      = i_req_vld[r_rr_pri] ? r_rr_pri : ~r_rr_pri;
  assign w_push     = (r_state == RUN) & o_rnd_en & w_any_req & (~w_full | w_pop);
  assign o_req_rdy  = w_push ? (w_win ? 2'b10 : 2'b01) : 2'b00;
  assign o_dp_dvld  = w_push;
  assign o_dp_b     = w_push ? (w_win ? i_req_b[2*MASKWIDTH-1:MASKWIDTH]
                                      : i_req_b[MASKWIDTH-1:0]) : '0;
  assign w_push_tag = tag_t'{src: w_win,
                             id:  (w_win ? i_req_id[2*ID_W-1:ID_W] : i_req_id[ID_W-1:0])};
  assign w_count_nxt = w_count + CW'(w_push) - CW'(w_pop_eff);

  b2a_tag_fifo #(
    .WIDTH ($bits(tag_t)),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_din   (w_push_tag),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Next state; idle decisions look at occupancy after this cycle's push/pop
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any_req && !i_flush) w_state_nxt = RUN;
      RUN:     if (i_flush) w_state_nxt = DRAIN;
               else if (!w_any_req && w_count_nxt == '0) w_state_nxt = IDLE;
      DRAIN:   if (w_count_nxt == '0) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, arbitration pointer and sticky protocol error
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_rr_pri <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_rr_pri <= ~w_win;
      if ((w_pop && w_empty) || (w_push && w_full && !w_pop)) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_b2a_sched.sv
// Randomized bench for b2a_sched: behavioural datapath plus queue-based reference.
module tb_b2a_sched;
  import b2a_pkg::*;

  localparam int KW = 32, NS = 3, MW = KW * NS, IW = 4, DEPTH = 32, LAT = 24;

  logic            clk_i = 1'b0, rst_i = 1'b1;
  logic [1:0]      i_req_vld = '0;
  logic [1:0]      o_req_rdy;
  logic [2*MW-1:0] i_req_b = '0;
  logic [2*IW-1:0] i_req_id = '0;
  logic            i_rnd_vld = 1'b1, o_rnd_en, o_dp_dvld;
  logic [MW-1:0]   o_dp_b, i_dp_a, o_a;
  logic            i_dp_dvld;
  logic            i_flush = 1'b0, o_vld, i_rdy = 1'b1, o_src, o_busy, o_err;
  logic [IW-1:0]   o_id;

  b2a_sched #(.K_WIDTH(KW), .N_SHARES(NS), .MASKWIDTH(MW), .ID_W(IW), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .i_req_vld(i_req_vld), .o_req_rdy(o_req_rdy),
    .i_req_b(i_req_b), .i_req_id(i_req_id), .i_rnd_vld(i_rnd_vld), .o_rnd_en(o_rnd_en),
    .o_dp_dvld(o_dp_dvld), .o_dp_b(o_dp_b), .i_dp_dvld(i_dp_dvld), .i_dp_a(i_dp_a),
    .i_flush(i_flush), .o_vld(o_vld), .i_rdy(i_rdy), .o_a(o_a), .o_src(o_src),
    .o_id(o_id), .o_busy(o_busy), .o_err(o_err));

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Stand-in conversion: any fixed bijection lets results be traced to inputs
  function automatic logic [MW-1:0] xf(input logic [MW-1:0] b);
    return {b[MW-2:0], b[MW-1]} ^ {3{32'h5A3C_96E1}};
  endfunction

  // Datapath: LAT-stage pipe that moves only when enabled
  logic          dp_v [LAT];
  logic [MW-1:0] dp_d [LAT];
  logic          force_dv = 1'b0;
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < LAT; i++) begin dp_v[i] <= 1'b0; dp_d[i] <= '0; end
    end else if (o_rnd_en) begin
      dp_v[0] <= o_dp_dvld;
      dp_d[0] <= o_dp_b;
      for (int i = 1; i < LAT; i++) begin dp_v[i] <= dp_v[i-1]; dp_d[i] <= dp_d[i-1]; end
    end
  end
  assign i_dp_dvld = dp_v[LAT-1] | force_dv;
  assign i_dp_a    = xf(dp_d[LAT-1]);

  // Reference: in-flight conversions as a queue, mode as 0 idle / 1 run / 2 drain
  typedef struct { logic src; logic [IW-1:0] id; logic [MW-1:0] b; } ent_t;
  ent_t q[$];
  int   mst = 0, last_g = 1;
  bit   merr = 0;
  logic [1:0] gnt_last = '0;
  int   n_dgnt = 0, n_dret = 0;
  logic last_src = 1'b0;
  logic [IW-1:0] last_id = '0;
  bit   alt_en = 0;
  int   gq[$];

  always @(negedge clk_i) begin
    if (rst_i) begin
      q.delete(); mst = 0; last_g = 1; merr = 0; gnt_last = '0;
    end else begin
      bit ren, ev, pop, push;
      int w;
      logic [1:0] eg;
      logic [MW-1:0] eb;
      ent_t e;
      ren = i_rnd_vld & ~(i_dp_dvld & ~i_rdy);
      ev  = i_dp_dvld & i_rnd_vld;
      pop = ev & i_rdy;
      w = -1;
      if (i_req_vld == 2'b11) w = 1 - last_g;
      else if (i_req_vld[0])  w = 0;
      else if (i_req_vld[1])  w = 1;
      push = (mst == 1) && ren && w >= 0 && (q.size() < DEPTH || (pop && q.size() > 0));
      eg = push ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00;
      eb = push ? ((w == 1) ? i_req_b[MW +: MW] : i_req_b[0 +: MW]) : '0;
      chk("rnd_en", o_rnd_en, ren);
      chk("vld", o_vld, ev);
      chk("busy", o_busy, mst != 0);
      chk("err", o_err, merr);
      chk("req_rdy", o_req_rdy, eg);
      chk("dp_dvld", o_dp_dvld, push);
      chk("dp_b", o_dp_b, eb);
      if (ev && q.size() > 0) begin
        chk("src", o_src, q[0].src);
        chk("id", o_id, q[0].id);
        chk("a", o_a, xf(q[0].b));
      end
      if (o_req_rdy != 2'b00) begin
        n_dgnt++;
        if (alt_en) gq.push_back(o_req_rdy[1] ? 1 : 0);
      end
      if (o_vld && i_rdy) begin n_dret++; last_src = o_src; last_id = o_id; end
      if (pop) begin
        if (q.size() == 0) merr = 1;
        else void'(q.pop_front());
      end
      if (push) begin
        e.src = (w == 1);
        e.id  = (w == 1) ? i_req_id[IW +: IW] : i_req_id[0 +: IW];
        e.b   = eb;
        q.push_back(e);
        last_g = w;
      end
      gnt_last = eg;
      case (mst)
        0: if (i_req_vld != 0 && !i_flush) mst = 1;
        1: if (i_flush) mst = 2; else if (i_req_vld == 0 && q.size() == 0) mst = 0;
        2: if (q.size() == 0) mst = 0;
        default: mst = 0;
      endcase
    end
  end

  // Driver knobs
  bit auto_req = 0, rdy_rand = 0;
  int p_req = 100, rnd_mode = 0;
  logic [IW-1:0] nid [2] = '{4'd0, 4'd8};

  task automatic step();
    @(posedge clk_i); #1;
    if (rnd_mode == 0)      i_rnd_vld = 1'b1;
    else if (rnd_mode == 1) i_rnd_vld = ~i_rnd_vld;
    else                    i_rnd_vld = ($urandom_range(99) < 75);
    if (rdy_rand) i_rdy = ($urandom_range(99) < 70);
    if (auto_req)
      for (int r = 0; r < 2; r++)
        if (gnt_last[r] || !i_req_vld[r]) begin
          i_req_vld[r] = ($urandom_range(99) < p_req);
          i_req_b[r*MW +: MW] = {$urandom, $urandom, $urandom};
          i_req_id[r*IW +: IW] = nid[r];
          if (i_req_vld[r]) nid[r] = nid[r] + 1'b1;
        end
  endtask

  task automatic settle();
    @(negedge clk_i); #1;
  endtask

  task automatic wait_idle(input int max, input string tag);
    int c = 0;
    while ((o_busy || q.size() != 0) && c < max) begin step(); settle(); c++; end
    chk(tag, (o_busy || q.size() != 0), 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bg, br, bad, c;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    settle();
    chk("rst_req_rdy", o_req_rdy, 2'b00);
    chk("rst_dp_dvld", o_dp_dvld, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_vld", o_vld, 1'b0);
    chk("rst_err", o_err, 1'b0);

    // Single request r0, id 3
    bg = n_dgnt; br = n_dret;
    step(); i_req_vld = 2'b01; i_req_id = 8'h03; i_req_b[0 +: MW] = {$urandom, $urandom, $urandom};
    settle();
    c = 0;
    while (!gnt_last[0] && c < 10) begin step(); settle(); c++; end
    step(); i_req_vld = 2'b00; settle();
    wait_idle(100, "t1_idle");
    chk("t1_issues", n_dgnt - bg, 1);
    chk("t1_rets", n_dret - br, 1);
    chk("t1_src", last_src, 1'b0);
    chk("t1_id", last_id, 4'd3);
    chk("t1_busy", o_busy, 1'b0);

    // Both requesters always valid: alternate, one issue per cycle
    bg = n_dgnt; br = n_dret; gq.delete(); alt_en = 1;
    auto_req = 1; p_req = 100;
    repeat (30) begin step(); settle(); end
    alt_en = 0;
    chk("t2_issue_rate", n_dgnt - bg, 29);
    bad = 0;
    for (int i = 1; i < gq.size(); i++) if (gq[i] == gq[i-1]) bad++;
    chk("t2_alternate", bad, 0);
    auto_req = 0; step(); i_req_vld = 2'b00; settle();
    wait_idle(200, "t2_idle");
    chk("t2_all_back", n_dret - br, n_dgnt - bg);

    // Randomness toggling: stalls delay but never lose results
    bg = n_dgnt; br = n_dret;
    rnd_mode = 1; auto_req = 1; p_req = 60;
    repeat (40) begin step(); settle(); end
    auto_req = 0; step(); i_req_vld = 2'b00; settle();
    wait_idle(300, "t3_idle");
    chk("t3_all_back", n_dret - br, n_dgnt - bg);
    rnd_mode = 0;

    // Output backpressure holds the result and freezes the pipe
    bg = n_dgnt; br = n_dret;
    step(); i_rdy = 1'b0; auto_req = 1; p_req = 100; settle();
    repeat (3) begin step(); settle(); end
    auto_req = 0; step(); i_req_vld = 2'b00; settle();
    c = 0;
    while (!i_dp_dvld && c < 100) begin step(); settle(); c++; end
    chk("t4_result_seen", i_dp_dvld, 1'b1);
    repeat (10) begin
      chk("t4_vld_held", o_vld, 1'b1);
      chk("t4_en_low", o_rnd_en, 1'b0);
      if (q.size() > 0) chk("t4_a_stable", o_a, xf(q[0].b));
      step(); settle();
    end
    chk("t4_none_taken", n_dret - br, 0);
    step(); i_rdy = 1'b1; settle();
    wait_idle(200, "t4_idle");
    chk("t4_all_back", n_dret - br, n_dgnt - bg);

    // 20 in flight, then flush with requests still pending
    bg = n_dgnt; br = n_dret;
    auto_req = 1; p_req = 100;
    c = 0;
    while (n_dgnt - bg < 20 && c < 40) begin step(); settle(); c++; end
    auto_req = 0; step(); i_req_vld = 2'b00; i_flush = 1'b1; settle();
    chk("t5_in_flight", n_dgnt - bg, 20);
    bg = n_dgnt;
    step(); i_req_vld = 2'b11; settle();
    c = 0;
    while (o_busy && c < 100) begin step(); settle(); c++; end
    chk("t5_no_grant", n_dgnt - bg, 0);
    chk("t5_returned", n_dret - br, 20);
    chk("t5_busy", o_busy, 1'b0);
    repeat (3) begin step(); settle(); end
    chk("t5_flush_idle", o_busy, 1'b0);
    step(); i_flush = 1'b0; i_req_vld = 2'b00; settle();

    // Random soak
    bg = n_dgnt; br = n_dret;
    auto_req = 1; p_req = 50; rnd_mode = 2; rdy_rand = 1;
    repeat (400) begin step(); i_flush = ($urandom_range(99) < 3); settle(); end
    auto_req = 0; rdy_rand = 0; rnd_mode = 0;
    step(); i_req_vld = 2'b00; i_flush = 1'b0; i_rdy = 1'b1; settle();
    wait_idle(500, "t6_idle");
    chk("t6_all_back", n_dret - br, n_dgnt - bg);

    // Reset in the middle of traffic (datapath reset with it)
    auto_req = 1; p_req = 100;
    repeat (10) begin step(); settle(); end
    auto_req = 0; step(); rst_i = 1'b1; i_req_vld = 2'b00; settle();
    step(); step(); rst_i = 1'b0; settle();
    chk("t7_busy", o_busy, 1'b0);
    chk("t7_vld", o_vld, 1'b0);
    chk("t7_err", o_err, 1'b0);

    // Result with no tag outstanding: sticky error until reset
    step(); force_dv = 1'b1; settle();
    chk("t8_vld", o_vld, 1'b1);
    step(); force_dv = 1'b0; settle();
    chk("t8_err_set", o_err, 1'b1);
    repeat (5) begin step(); settle(); end
    chk("t8_err_sticky", o_err, 1'b1);
    step(); rst_i = 1'b1; settle();
    chk("t8_err_clr", o_err, 1'b0);
    step(); rst_i = 1'b0; settle();
    chk("t8_err_after", o_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/b2a_sched.md
# b2a_sched

Scheduler that shares one masked Boolean-to-arithmetic conversion pipeline (n-share, k-bit, fixed latency, global stall through its randomness-valid enable) between two requesters. It arbitrates requests round-robin, gates the pipeline enable on randomness availability and output backpressure, and tags every in-flight conversion so each result returns with its requester and ID. Sits between the requester ports and the conversion datapath; the datapath and randomness source are external.

## Interface
- K_WIDTH, 32, bits per share
- N_SHARES, 3, number of shares
- MASKWIDTH, K_WIDTH*N_SHARES, share-vector width
- ID_W, 4, requester transaction-ID width
- DEPTH, 32, tag FIFO depth; must be ≥ datapath latency in enabled cycles (power of two)

Ports:
- clk_i  in  1  clock; only clock
- rst_i  in  1  reset, asynchronous, active-high
- i_req_vld  in  2  per-requester request valid
- o_req_rdy  out  2  per-requester grant/accept
- i_req_b  in  2*MASKWIDTH  Boolean shares, requester r at [r*MASKWIDTH +: MASKWIDTH]
- i_req_id  in  2*ID_W  request IDs
- i_rnd_vld  in  1  randomness word valid this cycle
- o_rnd_en  out  1  drives datapath enable (i_rvld); randomness consumed when high
- o_dp_dvld  out  1  datapath input valid
- o_dp_b  out  MASKWIDTH  datapath Boolean shares
- i_dp_dvld  in  1  datapath output valid
- i_dp_a  in  MASKWIDTH  datapath arithmetic shares
- i_flush  in  1  stop issuing, drain pipeline
- o_vld / i_rdy  out/in  1/1  result handshake
- o_a  out  MASKWIDTH  arithmetic shares
- o_src  out  1  requester index of result
- o_id  out  ID_W  ID of result
- o_busy  out  1  state ≠ IDLE
- o_err  out  1  sticky: result with empty tag FIFO, or issue with full FIFO

## Operation
- Enable: o_rnd_en = i_rnd_vld & ~(i_dp_dvld & ~i_rdy). Datapath advances only when o_rnd_en=1.
- Output: o_vld = i_dp_dvld & i_rnd_vld; o_a = i_dp_a; {o_src,o_id} = tag FIFO head. Result accepted (FIFO pop) when o_vld & i_rdy.
- Issue allowed when state=RUN, o_rnd_en=1, FIFO not full (count<DEPTH, counting same-cycle pop as freeing). On issue: round-robin pick among valid requesters (last-granted gets lowest priority; reset pointer favours requester 0), o_req_rdy one-hot for winner, o_dp_dvld=1, o_dp_b=winner shares, push {src,id}. o_dp_dvld=0, o_dp_b=0 otherwise.
- Simultaneous push and pop: count unchanged; both take effect; FIFO pointers wrap mod DEPTH.
- FSM: IDLE -> RUN when any i_req_vld & ~i_flush; RUN -> DRAIN on i_flush; RUN -> IDLE when no request and count=0 (after pops); DRAIN -> IDLE when count=0; DRAIN never issues; i_flush ignored in IDLE.
- o_err set on pop with count=0 or push with count=DEPTH; cleared only by reset.

## Timing
- Reset (async assert, sync release): state IDLE, FIFO empty, count 0, RR pointer 0, o_err 0; outputs o_req_rdy=0, o_dp_dvld=0, o_busy=0, o_vld follows inputs (0 while i_dp_dvld=0).
- Issue is combinational in the cycle of arbitration: request accepted and presented to datapath in the same cycle; one issue per enabled cycle max, full throughput.
- FSM transitions registered; first issue one cycle after IDLE->RUN request seen.
- Result latency = datapath latency in enabled cycles; stalled cycles (o_rnd_en=0) add delay, no loss.
- Reset mid-operation: tags discarded; results then arriving raise o_err (bench must also reset datapath).

## Structure
- Package b2a_pkg: K_WIDTH/N_SHARES defaults, tag struct {src, id}, FSM state enum {IDLE, RUN, DRAIN}.
- One sub-module: b2a_tag_fifo (DEPTH×(1+ID_W) register FIFO, count, full/empty, async active-high reset).

## Test plan
- Single request r0 id=3, i_rnd_vld=1, i_rdy=1 -> one o_dp_dvld pulse, result after latency with o_src=0, o_id=3, FIFO count back to 0, IDLE.
- Both requesters always valid, IDs incrementing -> grants alternate 0,1,0,1; results in issue order with matching tags; one issue per cycle.
- i_rnd_vld toggled 1,0,1,0 -> o_rnd_en and issues only on 1 cycles; results delayed 2× latency, none lost/duplicated.
- i_rdy=0 for 10 cycles with result pending -> o_rnd_en=0, o_vld held, o_a stable; resume yields same result once.
- 20 in flight, assert i_flush -> no further o_req_rdy, all 20 returned, then IDLE, o_busy=0.
- Force i_dp_dvld with empty FIFO -> o_err=1 sticky until rst_i.
